// File: rtl/jk_drive_seq.sv
// jk_drive_seq: buffers target Q vectors and converts each one into a one-cycle J/K drive pulse for a JK flop bank.
// Optional feature macro: JK_CHECK_EN enables the Q feedback comparator and the err/err_count outputs.
module jk_drive_seq #(
    parameter int               WIDTH      = 4,
    parameter int               DEPTH      = 4,
    parameter int               USE_TOGGLE = 0,
    parameter logic [WIDTH-1:0] Q_INIT     = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] q_fb,
    output logic             busy,
    output logic             err,
    output logic [7:0]       err_count,
    input  logic             clr_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] enc_j;
    logic [WIDTH-1:0] enc_k;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    // A new target may only be popped when no pulse is in flight (IDLE or CHECK).
    assign push = tgt_valid && !fifo_full;
    assign pop  = (state_q != SETTLE) && !fifo_empty;

    // Excitation table: bits that already match hold, changed bits are set/reset or toggled.
    assign diff  = shadow_q ^ head;
    assign enc_j = (USE_TOGGLE != 0) ? diff : (diff & head);
    assign enc_k = (USE_TOGGLE != 0) ? diff : (diff & ~head);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = tgt_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        j_d      = '0;
        k_d      = '0;
        unique case (state_q)
            IDLE, CHECK: begin
                if (pop) begin
                    j_d      = enc_j;
                    k_d      = enc_k;
                    shadow_d = head;
                    state_d  = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                state_d = CHECK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shadow_q <= Q_INIT;
            j_q      <= '0;
            k_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            j_q      <= j_d;
            k_q      <= k_d;
            mem_q    <= mem_d;
        end
    end

    assign J         = j_q;
    assign K         = k_q;
    assign tgt_ready = !fifo_full;
    assign busy      = (state_q != IDLE) || !fifo_empty;

`ifdef JK_CHECK_EN
    logic       err_q, err_d;
    logic [7:0] err_count_q, err_count_d;
    logic       mismatch;

    // The bank has had a full cycle to settle once the FSM sits in CHECK.
    assign mismatch = (state_q == CHECK) && (q_fb != shadow_q);

    always_comb begin
        err_d       = err_q;
        err_count_d = err_count_q;
        if (clr_err) begin
            err_d       = 1'b0;
            err_count_d = '0;
        end else if (mismatch) begin
            err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign err       = err_q;
    assign err_count = err_count_q;
`else
    logic unused_check_inputs;

    assign unused_check_inputs = ^{q_fb, clr_err};
    assign err                 = 1'b0;
    assign err_count           = '0;
`endif

    // J/K may only be non-zero during the single SETTLE cycle.
    a_pulse_only_in_settle: assert property (@(posedge Clk) disable iff (Rst)
        (state_q != SETTLE) |-> ((j_q == '0) && (k_q == '0)));

    a_no_toggle_in_setreset: assert property (@(posedge Clk) disable iff (Rst)
        (USE_TOGGLE == 0) |-> ((j_q & k_q) == '0));

    a_count_bounded: assert property (@(posedge Clk) disable iff (Rst)
        count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_jk_drive_seq.sv
// Testbench for jk_drive_seq: set/reset and toggle instances share stimulus and are checked against a schedule-based model.
module tb_jk_drive_seq;

    localparam int W = 4;
    localparam int D = 4;
`ifdef JK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         tgt_valid = 1'b0;
    logic [W-1:0] tgt_data = '0;
    logic         clr_err = 1'b0;
    logic [W-1:0] inj = '0;

    logic         rdy0, busy0, err0, rdyt, busyt, errt;
    logic [W-1:0] J0, K0, Jt, Kt;
    logic [7:0]   cnt0, cntt;
    logic [W-1:0] q_fb0, q_fbt;

    // Flop bank models: updated at the edge, made visible to the DUT at the following negedge.
    logic [W-1:0] bank0, bankt, vis0, vist;
    logic [W-1:0] js0, ks0, jst, kst;

    assign q_fb0 = vis0 ^ inj;
    assign q_fbt = vist ^ inj;

    always #5 Clk = ~Clk;

    jk_drive_seq #(.WIDTH(W), .DEPTH(D), .USE_TOGGLE(0), .Q_INIT('0)) dut (
        .Clk(Clk), .Rst(Rst), .tgt_valid(tgt_valid), .tgt_ready(rdy0), .tgt_data(tgt_data),
        .J(J0), .K(K0), .q_fb(q_fb0), .busy(busy0), .err(err0), .err_count(cnt0), .clr_err(clr_err));

    jk_drive_seq #(.WIDTH(W), .DEPTH(D), .USE_TOGGLE(1), .Q_INIT('0)) dut_t (
        .Clk(Clk), .Rst(Rst), .tgt_valid(tgt_valid), .tgt_ready(rdyt), .tgt_data(tgt_data),
        .J(Jt), .K(Kt), .q_fb(q_fbt), .busy(busyt), .err(errt), .err_count(cntt), .clr_err(clr_err));

    typedef struct {
        logic [W-1:0] data;
        int           drive;
    } ent_t;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic [W-1:0] j, k, jt, kt;
        logic         rdy, bsy;
    } vec_t;

    ent_t         pend[$];
    int           n_edge, last_sched, last_pop, chk_at;
    logic [W-1:0] shadow;
    logic [W-1:0] exp_j, exp_k, exp_jt, exp_kt;
    logic         exp_rdy, exp_busy, exp_err0, exp_errt;
    logic [7:0]   exp_cnt0, exp_cntt;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, input logic [W-1:0] j, input logic [W-1:0] k);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            case ({j[i], k[i]})
                2'b00:   r[i] = q[i];
                2'b01:   r[i] = 1'b0;
                2'b10:   r[i] = 1'b1;
                default: r[i] = ~q[i];
            endcase
        end
        return r;
    endfunction

    function automatic void encode(input logic [W-1:0] s, input logic [W-1:0] t, input bit tog,
                                   output logic [W-1:0] j, output logic [W-1:0] k);
        for (int i = 0; i < W; i++) begin
            if (s[i] == t[i]) begin
                j[i] = 1'b0; k[i] = 1'b0;
            end else if (tog) begin
                j[i] = 1'b1; k[i] = 1'b1;
            end else begin
                j[i] = t[i]; k[i] = ~t[i];
            end
        end
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'd255) ? c : c + 8'd1;
    endfunction

    task automatic model_reset();
        pend.delete();
        last_sched = -1000;
        last_pop   = -1000;
        chk_at     = -1000;
        shadow     = '0;
        exp_j = '0; exp_k = '0; exp_jt = '0; exp_kt = '0;
        exp_rdy = 1'b1; exp_busy = 1'b0;
        exp_err0 = 1'b0; exp_errt = 1'b0; exp_cnt0 = '0; exp_cntt = '0;
        bank0 = '0; bankt = '0; vis0 = '0; vist = '0;
        js0 = '0; ks0 = '0; jst = '0; kst = '0;
    endtask

    // Each accepted target is scheduled at max(accept+1, previous drive+2); its check falls two edges later.
    task automatic model_edge();
        bit   rdy_pre;
        ent_t e;
        bank0   = jk_next(bank0, js0, ks0);
        bankt   = jk_next(bankt, jst, kst);
        rdy_pre = (pend.size() < D);
        if (CHK) begin
            if (clr_err) begin
                exp_err0 = 1'b0; exp_cnt0 = '0; exp_errt = 1'b0; exp_cntt = '0;
            end else if (n_edge == chk_at) begin
                if (q_fb0 != shadow) begin exp_err0 = 1'b1; exp_cnt0 = sat_inc(exp_cnt0); end
                if (q_fbt != shadow) begin exp_errt = 1'b1; exp_cntt = sat_inc(exp_cntt); end
            end
        end
        exp_j = '0; exp_k = '0; exp_jt = '0; exp_kt = '0;
        if (pend.size() > 0 && pend[0].drive == n_edge) begin
            e = pend.pop_front();
            encode(shadow, e.data, 1'b0, exp_j, exp_k);
            encode(shadow, e.data, 1'b1, exp_jt, exp_kt);
            shadow   = e.data;
            chk_at   = n_edge + 2;
            last_pop = n_edge;
        end
        if (tgt_valid && rdy_pre) begin
            e.data     = tgt_data;
            e.drive    = (n_edge + 1 > last_sched + 2) ? n_edge + 1 : last_sched + 2;
            last_sched = e.drive;
            pend.push_back(e);
        end
        exp_rdy  = (pend.size() < D);
        exp_busy = (pend.size() != 0) || (n_edge < last_pop + 2);
    endtask

    task automatic compare_all();
        check_output("J", J0, exp_j);
        check_output("K", K0, exp_k);
        check_output("J_tog", Jt, exp_jt);
        check_output("K_tog", Kt, exp_kt);
        check_output("tgt_ready", rdy0, exp_rdy);
        check_output("tgt_ready_tog", rdyt, exp_rdy);
        check_output("busy", busy0, exp_busy);
        check_output("busy_tog", busyt, exp_busy);
        check_output("err", err0, exp_err0);
        check_output("err_count", cnt0, exp_cnt0);
        check_output("err_tog", errt, exp_errt);
        check_output("err_count_tog", cntt, exp_cntt);
    endtask

    // One clock: model advances at the edge, outputs are compared at the following negedge.
    task automatic apply_stimulus();
        @(posedge Clk);
        if (!Rst) model_edge();
        n_edge++;
        @(negedge Clk);
        vis0 = bank0;
        vist = bankt;
        compare_all();
        js0 = J0; ks0 = K0; jst = Jt; kst = Kt;
    endtask

    task automatic do_reset();
        tgt_valid = 1'b0;
        clr_err   = 1'b0;
        inj       = '0;
        Rst       = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(posedge Clk);
        n_edge++;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    vec_t         tv[10];
    logic [W-1:0] seq8[8];
    logic [W-1:0] obs[$];
    logic [W-1:0] recon;
    int           idx;
    bit           saw_low, acc;

    initial begin
        n_edge = 0;
        model_reset();
        tv[0] = '{1'b1, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1};
        tv[1] = '{1'b1, 4'b0110, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 1'b1, 1'b1};
        tv[2] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1};
        tv[3] = '{1'b0, 4'b0000, 4'b0100, 4'b1000, 4'b1100, 4'b1100, 1'b1, 1'b1};
        tv[4] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1};
        tv[5] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tv[6] = '{1'b1, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1};
        tv[7] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1};
        tv[8] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1};
        tv[9] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        seq8 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0101};

        @(negedge Clk);
        do_reset();

        // Excitation sequence 1010 -> 0110, then a target equal to the shadow.
        for (int i = 0; i < 10; i++) begin
            tgt_valid = tv[i].v;
            tgt_data  = tv[i].d;
            apply_stimulus();
            check_output($sformatf("vec%0d_J", i), J0, tv[i].j);
            check_output($sformatf("vec%0d_K", i), K0, tv[i].k);
            check_output($sformatf("vec%0d_Jtog", i), Jt, tv[i].jt);
            check_output($sformatf("vec%0d_Ktog", i), Kt, tv[i].kt);
            check_output($sformatf("vec%0d_ready", i), rdy0, tv[i].rdy);
            check_output($sformatf("vec%0d_busy", i), busy0, tv[i].bsy);
        end

        // Eight targets with tgt_valid held: back-pressure and in-order drive.
        do_reset();
        idx = 0; saw_low = 0; recon = '0; obs.delete();
        tgt_valid = 1'b1;
        tgt_data  = seq8[0];
        for (int c = 0; c < 60 && (idx < 8 || busy0); c++) begin
            acc = tgt_valid && rdy0;
            apply_stimulus();
            if (acc) idx++;
            if (idx < 8) tgt_data = seq8[idx];
            else tgt_valid = 1'b0;
            if (!rdy0) saw_low = 1'b1;
            if ((J0 | K0) != '0) begin
                recon = (recon | J0) & ~K0;
                obs.push_back(recon);
            end
        end
        check_output("fill_all_accepted", idx, 8);
        check_output("fill_ready_dropped", saw_low, 1);
        check_output("fill_drained", busy0, 0);
        check_output("fill_pulse_count", obs.size(), 8);
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            check_output($sformatf("fill_order%0d", i), obs[i], seq8[i]);
        end

        // Forced bit-0 feedback error, then clear.
        do_reset();
        inj = 4'b0001;
        tgt_valid = 1'b1; tgt_data = 4'b0001;
        apply_stimulus();
        tgt_valid = 1'b0;
        repeat (3) apply_stimulus();
        check_output("inj_err", err0, CHK);
        check_output("inj_err_count", cnt0, CHK ? 1 : 0);
        clr_err = 1'b1;
        apply_stimulus();
        clr_err = 1'b0;
        check_output("clr_err", err0, 0);
        check_output("clr_err_count", cnt0, 0);
        inj = '0;

        // Random traffic, with occasional feedback corruption and clears.
        for (int c = 0; c < 800; c++) begin
            tgt_valid = ($urandom_range(0, 9) < 7);
            tgt_data  = 4'($urandom);
            clr_err   = ($urandom_range(0, 19) == 0);
            inj       = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
            apply_stimulus();
        end

        // Every check mismatches: the counter must stick at 255.
        clr_err = 1'b0;
        apply_stimulus();
        inj = 4'hF;
        for (int c = 0; c < 600; c++) begin
            tgt_valid = 1'b1;
            tgt_data  = 4'($urandom);
            apply_stimulus();
        end
        check_output("sat_count", cnt0, CHK ? 255 : 0);

        // Reset in the middle of traffic, then targets from a fresh shadow.
        do_reset();
        check_output("rst_J", J0, 0);
        check_output("rst_busy", busy0, 0);
        tgt_valid = 1'b1; tgt_data = 4'b0000;
        apply_stimulus();
        tgt_valid = 1'b0;
        apply_stimulus();
        check_output("zero_J", J0, 0);
        check_output("zero_K", K0, 0);
        check_output("zero_busy", busy0, 1);
        repeat (2) apply_stimulus();
        check_output("zero_no_err", err0, 0);
        tgt_valid = 1'b1; tgt_data = 4'b1010;
        apply_stimulus();
        tgt_valid = 1'b0;
        apply_stimulus();
        check_output("post_rst_J", J0, 4'b1010);
        check_output("post_rst_K", K0, 4'b0000);
        repeat (3) apply_stimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
